// File: rtl/proc_pkg.sv
// Shared datapath constants for the register file and writeback mux control.
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    localparam logic [ADDR_W-1:0] REG_ZERO = 4'd0;

    // Writeback-select encodings consumed by the four-way writeback mux.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC2 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_e;

    // One-hot select of a register index; r0 never gets a bit since it is hardwired.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en, input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec = {NUM_REGS{1'b0}};
        if (en && (addr != REG_ZERO)) begin
            vec[addr] = 1'b1;
        end else begin
            vec = {NUM_REGS{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register (r0 never busy).
module reg_scoreboard
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] set_s;
    logic [NUM_REGS-1:0] clr_s;
    logic [NUM_REGS-1:0] busy_next_s;

    // Next busy vector: a new issue to the same register outranks its writeback.
    always_comb begin
        set_s       = reg_onehot(issue_en, issue_addr);
        clr_s       = reg_onehot(wb_en, wb_addr);
        busy_next_s = (busy_r & ~clr_s) | set_s;
    end

    // Busy state; reset discards every pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Source hazards, masked when the write is being bypassed this very cycle.
    always_comb begin
        busy_a   = 1'b0;
        busy_b   = 1'b0;
        any_busy = |busy_r;
        if (busy_r[rd_addr_a] && !(wb_en && (wb_addr == rd_addr_a))) begin
            busy_a = 1'b1;
        end else begin
            busy_a = 1'b0;
        end
        if (busy_r[rd_addr_b] && !(wb_en && (wb_addr == rd_addr_b))) begin
            busy_b = 1'b1;
        end else begin
            busy_b = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_wb.sv
// 16x16 register file fed by the writeback mux, with same-cycle bypass and hazard scoreboard.
module reg_file_wb
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              any_busy
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Storage array; r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_en && (wb_addr != REG_ZERO)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Port A read: zero during reset and for r0, bypass on a matching writeback.
    always_comb begin
        rd_data_a = {DATA_W{1'b0}};
        if (!reset || (rd_addr_a == REG_ZERO)) begin
            rd_data_a = {DATA_W{1'b0}};
        end else if (wb_en && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Port B read: same selection as port A.
    always_comb begin
        rd_data_b = {DATA_W{1'b0}};
        if (!reset || (rd_addr_b == REG_ZERO)) begin
            rd_data_b = {DATA_W{1'b0}};
        end else if (wb_en && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

    reg_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .any_busy   (any_busy)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed testbench for reg_file_wb.
module tb_reg_file_wb;

    logic        clk;
    logic        reset;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        issue_en;
    logic [3:0]  issue_addr;
    logic        busy_a;
    logic        busy_b;
    logic        any_busy;

    int total;
    int bad;

    reg_file_wb dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_a     (busy_a),
        .busy_b     (busy_b),
        .any_busy   (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held with a writeback trying to land on r3.
        reset = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd3;
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        issue_en = 1'b1; issue_addr = 4'd3;
        repeat (10) @(posedge clk);
        #1;
        check("rst_rd_a", rd_data_a, 16'h0000);
        check("rst_rd_b", rd_data_b, 16'h0000);
        check("rst_any_busy", {15'd0, any_busy}, 16'h0000);
        check("rst_busy_a", {15'd0, busy_a}, 16'h0000);

        // Release between edges, with no write pending: r3 still empty.
        wb_en = 1'b0; issue_en = 1'b0; reset = 1'b1;
        #1;
        check("rel_rd_a_before_edge", rd_data_a, 16'h0000);
        wb_en = 1'b1;
        step();
        wb_en = 1'b0;
        #1;
        check("rel_rd_a_after_edge", rd_data_a, 16'h1234);

        // Write and read back.
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hA5A5;
        step();
        wb_addr = 4'd15; wb_data = 16'h0001;
        step();
        wb_en = 1'b0; rd_addr_a = 4'd5; rd_addr_b = 4'd15;
        #1;
        check("rb_r5", rd_data_a, 16'hA5A5);
        check("rb_r15", rd_data_b, 16'h0001);

        // Writes to r0 are dropped, including via bypass.
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF; rd_addr_a = 4'd0;
        #1;
        check("r0_bypass", rd_data_a, 16'h0000);
        step();
        wb_en = 1'b0;
        #1;
        check("r0_after", rd_data_a, 16'h0000);

        // Bypass: r7 holds 0010, new value 0020 visible in the write cycle.
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h0010;
        step();
        wb_en = 1'b0; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        #1;
        check("byp_r7_old", rd_data_a, 16'h0010);
        wb_en = 1'b1; wb_data = 16'h0020;
        #1;
        check("byp_a_same_cycle", rd_data_a, 16'h0020);
        check("byp_b_same_cycle", rd_data_b, 16'h0020);
        step();
        wb_en = 1'b0;
        #1;
        check("byp_a_after", rd_data_a, 16'h0020);
        check("byp_b_after", rd_data_b, 16'h0020);

        // Scoreboard hazard on r4.
        issue_en = 1'b1; issue_addr = 4'd4; rd_addr_a = 4'd4; rd_addr_b = 4'd5;
        #1;
        check("sb_busy_before_edge", {15'd0, busy_a}, 16'h0000);
        step();
        issue_en = 1'b0;
        #1;
        check("sb_busy_a_set", {15'd0, busy_a}, 16'h0001);
        check("sb_any_set", {15'd0, any_busy}, 16'h0001);
        check("sb_busy_b_other", {15'd0, busy_b}, 16'h0000);
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h0042;
        #1;
        check("sb_busy_a_bypassed", {15'd0, busy_a}, 16'h0000);
        check("sb_rd_a_bypass", rd_data_a, 16'h0042);
        check("sb_any_still_set", {15'd0, any_busy}, 16'h0001);
        step();
        wb_en = 1'b0;
        #1;
        check("sb_busy_a_clear", {15'd0, busy_a}, 16'h0000);
        check("sb_any_clear", {15'd0, any_busy}, 16'h0000);
        check("sb_r4_value", rd_data_a, 16'h0042);

        // Simultaneous set and clear on r9: set wins, data lands.
        issue_en = 1'b1; issue_addr = 4'd9;
        step();
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 16'h0BEE;
        step();
        issue_en = 1'b0; wb_en = 1'b0; rd_addr_a = 4'd9;
        #1;
        check("sc_r9_data", rd_data_a, 16'h0BEE);
        check("sc_r9_busy", {15'd0, busy_a}, 16'h0001);
        check("sc_any", {15'd0, any_busy}, 16'h0001);
        wb_en = 1'b1;
        step();
        wb_en = 1'b0;
        #1;
        check("sc_r9_drained", {15'd0, any_busy}, 16'h0000);

        // Async reset mid-operation: r6=7777, r2 and r6 busy.
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 16'h7777;
        step();
        wb_en = 1'b0; issue_en = 1'b1; issue_addr = 4'd6;
        step();
        issue_addr = 4'd2;
        step();
        issue_en = 1'b0; rd_addr_a = 4'd6; rd_addr_b = 4'd2;
        #1;
        check("ar_pre_rd_a", rd_data_a, 16'h7777);
        check("ar_pre_busy_a", {15'd0, busy_a}, 16'h0001);
        check("ar_pre_busy_b", {15'd0, busy_b}, 16'h0001);
        #1;
        reset = 1'b0;
        #1;
        check("ar_rd_a", rd_data_a, 16'h0000);
        check("ar_busy_a", {15'd0, busy_a}, 16'h0000);
        check("ar_busy_b", {15'd0, busy_b}, 16'h0000);
        check("ar_any", {15'd0, any_busy}, 16'h0000);
        #1;
        reset = 1'b1;
        step();
        check("ar_post_r6", rd_data_a, 16'h0000);
        check("ar_post_any", {15'd0, any_busy}, 16'h0000);
        rd_addr_b = 4'd5;
        #1;
        check("ar_post_r5", rd_data_b, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 16-entry x 16-bit register file for the processor datapath, sitting directly downstream of the writeback four_way_mux_component.
- The mux output (ALU result / memory data / PC+2 / immediate) drives wb_data; the file stores it and serves two operand read ports.
- Contains a pending-write scoreboard so control can stall decode when a source register still awaits writeback.
- Same-cycle write-to-read bypass, so the writeback cycle itself needs no stall.

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 4, register address width
- NUM_REGS, 16, number of registers (equals 2**ADDR_W); r0 is hardwired to zero

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0); one clock, no other clock domains
- rd_addr_a  input  ADDR_W  read port A address
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_a  output  DATA_W  read port A data (combinational)
- rd_data_b  output  DATA_W  read port B data (combinational)
- wb_en  input  1  writeback strobe
- wb_addr  input  ADDR_W  writeback destination
- wb_data  input  DATA_W  writeback data, from the four-way writeback mux
- issue_en  input  1  instruction with a destination register is issued this cycle
- issue_addr  input  ADDR_W  destination of the issued instruction
- busy_a  output  1  port A source has a pending, not-yet-bypassable write
- busy_b  output  1  port B source has a pending, not-yet-bypassable write
- any_busy  output  1  OR of all scoreboard bits (drain indicator)

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear to 0; all busy bits clear
  - rd_data_a/b read 0; busy_a/b and any_busy are 0
  - a reset during a pending write discards the write and its busy bit
- Write: on rising clk, if wb_en=1 and wb_addr!=0, regs[wb_addr] <= wb_data. Writes to r0 are ignored.
- Read (combinational, zero latency):
  - rd_addr=0 -> 0
  - else if wb_en=1 and wb_addr==rd_addr -> wb_data (bypass)
  - else regs[rd_addr]
- Both ports may address the same register; both return the identical value.
- Scoreboard: busy[NUM_REGS-1:1]; busy[0] is constant 0.
  - rising clk, issue_en=1, issue_addr!=0: set busy[issue_addr]
  - rising clk, wb_en=1, wb_addr!=0: clear busy[wb_addr]
  - same address set and cleared in the same cycle: set wins (new writer pending); the write still lands
  - issue to an already-busy register: it stays busy; there is no counting, and in-order writeback is guaranteed by control
  - wb_en to a non-busy register: the write lands and busy stays 0
- busy_a = busy[rd_addr_a] AND NOT (wb_en AND wb_addr==rd_addr_a). busy_b is the same for port B. Both are 0 for address 0.
- any_busy = OR of busy bits (registered state only, no bypass term).
- Latency:
  - write visible through the array the cycle after wb_en
  - write visible through bypass in the same cycle
  - busy set visible the cycle after issue

Decomposition:
- Shared package proc_pkg holds:
  - DATA_W=16, ADDR_W=4, NUM_REGS=16, REG_ZERO=4'd0
  - writeback-select encodings used by the mux control: WB_ALU=2'b00, WB_MEM=2'b01, WB_PC2=2'b10, WB_IMM=2'b11
- One sub-module: reg_scoreboard, which holds the busy vector, set/clear logic, busy_a/busy_b/any_busy.
- Storage array, bypass and read muxing stay in the top.

Test Plan:
- Reset check: hold reset=0 for 10 cycles with wb_en=1, wb_addr=3, wb_data=16'h1234 -> rd_data_a(addr 3)=0, any_busy=0. Release reset -> still 0 until the next edge, then reads 16'h1234.
- Write/read back: write 16'hA5A5 to r5, 16'h0001 to r15; read a=5, b=15 next cycle -> 16'hA5A5 / 16'h0001. Write 16'hFFFF to r0 -> r0 reads 0.
- Bypass: r7=16'h0010. In the same cycle wb_en=1, wb_addr=7, wb_data=16'h0020, rd_addr_a=rd_addr_b=7 -> both read 16'h0020 that cycle and 16'h0020 after the edge.
- Scoreboard hazard:
  - issue_en on r4 -> next cycle busy_a(addr 4)=1, any_busy=1
  - wb to r4 with 16'h0042 -> same cycle busy_a=0, rd_data_a=16'h0042
  - next cycle busy=0, any_busy=0
- Simultaneous set/clear: r9 busy; in one cycle issue_en=1, issue_addr=9, wb_en=1, wb_addr=9, wb_data=16'h0BEE -> next cycle r9=16'h0BEE and busy_a(9)=1.
- Async reset mid-operation: r2, r6 busy and r6=16'h7777; pulse reset=0 between clock edges -> outputs go to 0 immediately, busy bits clear, any_busy=0.
